// File: rtl/pcs_encoder.sv
// pcs_encoder -- 64b/66b PCS block encoder fed by a 32-bit XGMII stream.
//
// Two consecutive accepted XGMII words form one 8-lane block. The first word
// holds lanes 0-3 and the second holds lanes 4-7. The block is encoded
// (data / idle / start / terminate / error) and registered into a one-entry
// output stage.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. A source never waits on ready before raising valid. While the
// output block is valid and not yet accepted, it holds its data unchanged.
//
// Ports:
//   clk               clock, all logic on rising edge
//   rst               asynchronous active-high reset
//   xgmii_data_in     XGMII data word, lane 0 in [7:0]
//   xgmii_ctrl_in     per-lane control flags, bit k for lane k
//   xgmii_valid_in    XGMII word valid
//   xgmii_ready_out   encoder accepts the XGMII word
//   encoded_data_out  66-bit block, sync header in [65:64]
//   encoded_valid_out block valid
//   encoded_ready_in  downstream accepts the block
//   enc_err_count     (only with PCS_ENC_ERR_CNT_EN) saturating count of
//                     error blocks loaded into the output register
//
// Optional feature macro: PCS_ENC_ERR_CNT_EN

module pcs_encoder #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int PCS_DATA_WIDTH   = 66
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XGMII_DATA_WIDTH-1:0] xgmii_data_in,
  input  logic [XGMII_DATA_BYTES-1:0] xgmii_ctrl_in,
  input  logic                        xgmii_valid_in,
  output logic                        xgmii_ready_out,
  output logic [PCS_DATA_WIDTH-1:0]   encoded_data_out,
  output logic                        encoded_valid_out,
  input  logic                        encoded_ready_in
`ifdef PCS_ENC_ERR_CNT_EN
  ,
  output logic [15:0]                 enc_err_count
`endif
);

  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } phase_t;

  localparam logic [65:0] ERR_BLOCK = {2'b10, 8'h1E, {7{8'hFE}}};

  phase_t                        phase_q, phase_d;
  logic [XGMII_DATA_WIDTH-1:0]   lo_data_q;
  logic [XGMII_DATA_BYTES-1:0]   lo_ctrl_q;
  logic [PCS_DATA_WIDTH-1:0]     out_data_q;
  logic                          out_valid_q;

  logic                          in_fire;
  logic                          out_fire;
  logic                          load_block;
  logic [63:0]                   blk_data;
  logic [7:0]                    blk_ctrl;
  logic [65:0]                   enc_block;
  logic                          enc_is_err;

  // Block type byte for a terminate character in lane n.
  function automatic logic [7:0] term_type(input int n);
    logic [7:0] t;
    case (n)
      0:       t = 8'h87;
      1:       t = 8'h99;
      2:       t = 8'hAA;
      3:       t = 8'hB4;
      4:       t = 8'hCC;
      5:       t = 8'hD2;
      6:       t = 8'hE1;
      default: t = 8'hFF;
    endcase
    return t;
  endfunction

  // Encode one 8-lane block. Anything that is not a recognised pattern
  // falls through to the error block.
  function automatic logic [65:0] encode_block(input logic [63:0] d,
                                               input logic [7:0]  c);
    logic [65:0] blk;
    logic [55:0] payload;
    logic        match;
    logic [7:0]  b;
    blk = ERR_BLOCK;
    if (c == 8'h00) begin
      blk = {2'b01, d};
    end else if (c == 8'hFF && d == {8{8'h07}}) begin
      blk = {2'b10, 8'h1E, {7{8'h07}}};
    end else if (c == 8'h01 && d[7:0] == 8'hFB) begin
      blk = {2'b10, 8'h78, d[15:8], d[23:16], d[31:24], d[39:32],
             d[47:40], d[55:48], d[63:56]};
    end else begin
      // Terminate in lane n: data below n, /T/ at n, idles above n.
      for (int n = 0; n < 8; n++) begin
        match = 1'b1;
        for (int k = 0; k < 8; k++) begin
          b = d[8*k +: 8];
          if (k < n)       match = match & !c[k];
          else if (k == n) match = match & c[k] & (b == 8'hFD);
          else             match = match & c[k] & (b == 8'h07);
        end
        if (match) begin
          payload = {7{8'h07}};
          for (int k = 0; k < 7; k++) begin
            if (k < n) payload[55-8*k -: 8] = d[8*k +: 8];
          end
          blk = {2'b10, term_type(n), payload};
        end
      end
    end
    return blk;
  endfunction

  // In PHASE_HI a block is produced, so the output register must be free or
  // draining this same cycle.
  assign xgmii_ready_out = (phase_q == PHASE_LO) || !out_valid_q || encoded_ready_in;
  assign in_fire         = xgmii_valid_in && xgmii_ready_out;
  assign out_fire        = out_valid_q && encoded_ready_in;
  assign load_block      = in_fire && (phase_q == PHASE_HI);

  assign blk_data   = {xgmii_data_in, lo_data_q};
  assign blk_ctrl   = {xgmii_ctrl_in, lo_ctrl_q};
  assign enc_block  = encode_block(blk_data, blk_ctrl);
  assign enc_is_err = (enc_block == ERR_BLOCK);

  assign encoded_data_out  = out_data_q;
  assign encoded_valid_out = out_valid_q;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PHASE_LO: if (in_fire) phase_d = PHASE_HI;
      PHASE_HI: if (in_fire) phase_d = PHASE_LO;
      default:  phase_d = PHASE_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PHASE_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Lower half store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_data_q <= '0;
      lo_ctrl_q <= '0;
    end else if (in_fire && phase_q == PHASE_LO) begin
      lo_data_q <= xgmii_data_in;
      lo_ctrl_q <= xgmii_ctrl_in;
    end
  end

  // Output register: a new load wins over a drain, so a simultaneous
  // drain-and-load keeps valid high with the new block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (load_block) begin
      out_data_q  <= enc_block;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PCS_ENC_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_err_count <= '0;
    end else if (load_block && enc_is_err && enc_err_count != 16'hFFFF) begin
      enc_err_count <= enc_err_count + 16'd1;
    end
  end
`else
  // Error flag only feeds the optional counter.
  logic unused_err;
  assign unused_err = enc_is_err;
`endif

endmodule
